mem_slot_arbiter: RTL and testbench

// - Sits downstream of the clock divider. Consumes cpu_phi / mem_phi as level inputs sampled on clock_50.
// - Time-slices one shared RAM bus between the CPU and the video fetcher.
// - Each mem_phi rising edge opens one slot. The slot owner is the cpu_phi level at that edge:
//   1 = CPU slot, 0 = video slot, so each cpu_phi half-period yields two slots.
// - Runs each slot as a fixed address/strobe/release sequence and returns read data with a 1-cycle ack.

---
 rtl/mem_slot_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_slot_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slot_arbiter.sv
// Time-slices one RAM bus between CPU and video: each mem_phi rise opens a slot owned by the cpu_phi level.
// Optional VIDEO_STEAL_EN: an idle CPU slot is handed to a pending video read.
module mem_slot_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int ACCESS_CYC = 4
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              cpu_phi,
    input  logic              mem_phi,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_oe,
    output logic              mem_we,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, ADDR, STROBE, RELEASE} state_t;

    localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic              mem_phi_d;
    logic [CNT_W-1:0]  cnt;
    logic              own_cpu;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic rise;
    logic steal;
    logic start_cpu;
    logic start_vid;

    assign rise = mem_phi & ~mem_phi_d;

`ifdef VIDEO_STEAL_EN
    assign steal = rise & cpu_phi & ~cpu_req & vid_req;
`else
    assign steal = 1'b0;
`endif

    assign start_cpu = rise & cpu_phi & cpu_req;
    assign start_vid = (rise & ~cpu_phi & vid_req) | steal;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_cpu || start_vid) next_state = ADDR;
            ADDR:    next_state = STROBE;
            STROBE:  if (cnt == LAST) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        vid_ack   = 1'b0;
        if (state != IDLE) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state == STROBE) begin
            mem_oe = ~we_q;
            mem_we = we_q;
        end
        if (state == RELEASE) begin
            cpu_ack = own_cpu;
            vid_ack = ~own_cpu;
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            mem_phi_d <= 1'b0;
            cnt       <= '0;
            own_cpu   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            vid_rdata <= '0;
            overrun   <= 1'b0;
        end else begin
            mem_phi_d <= mem_phi;
            if (state == IDLE && (start_cpu || start_vid)) begin
                own_cpu <= start_cpu;
                we_q    <= start_cpu & cpu_we;
                addr_q  <= start_cpu ? cpu_addr : vid_addr;
                wdata_q <= start_cpu ? cpu_wdata : '0;
            end
            cnt <= (state == STROBE) ? cnt + 1'b1 : '0;
            // Read data lands on the last strobe edge so it is valid alongside the ack.
            if (state == STROBE && cnt == LAST && !we_q) begin
                if (own_cpu) cpu_rdata <= mem_rdata;
                else         vid_rdata <= mem_rdata;
            end
            if (rise && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Bench for mem_slot_arbiter: drives the divider phases itself and scoreboards every ack.
module tb_mem_slot_arbiter;

    logic        clock_50 = 1'b0;
    logic        reset;
    logic        cpu_phi;
    logic        mem_phi;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_oe;
    logic        mem_we;
    logic        overrun;

    typedef struct packed {
        logic       is_cpu;
        logic       is_wr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic [7:0] got;
    int total = 0;
    int bad = 0;
    int ph = 39;
    bit fast = 1'b0;
    logic [7:0] ram [0:65535];

`ifdef VIDEO_STEAL_EN
    localparam int STEAL_ACK_PH = 8;
    localparam int STEAL_STROBES = 4;
`else
    localparam int STEAL_ACK_PH = 28;
    localparam int STEAL_STROBES = 0;
`endif

    mem_slot_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYC(4)) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .cpu_phi  (cpu_phi),
        .mem_phi  (mem_phi),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_rdata(vid_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .overrun  (overrun)
    );

    always #5 clock_50 = ~clock_50;

    // Divider: 40-cycle cpu_phi period, 10-cycle mem_phi period, rises at ph 2/12 (CPU) and 22/32 (video).
    initial begin
        mem_phi = 1'b0;
        cpu_phi = 1'b0;
        forever begin
            @(posedge clock_50);
            #1;
            if (fast) begin
                mem_phi = ~mem_phi;
                cpu_phi = 1'b1;
            end else begin
                ph      = (ph + 1) % 40;
                mem_phi = ((ph % 10) >= 2) && ((ph % 10) <= 6);
                cpu_phi = (ph < 20);
            end
        end
    end

    assign mem_rdata = ram[mem_addr];

    initial begin
        ram[16'h1234] = 8'hA5;
        ram[16'h2000] = 8'h11;
        ram[16'h2001] = 8'h22;
        ram[16'h2002] = 8'h33;
        ram[16'h0400] = 8'h00;
        forever begin
            @(negedge clock_50);
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
    end

    // Scoreboard and mutual-exclusion monitor.
    always @(negedge clock_50) begin
        if (!reset) begin
            total++;
            if (cpu_ack && vid_ack) begin
                bad++;
                $display("FAIL ack_excl cpu_ack=%b vid_ack=%b expected not both", cpu_ack, vid_ack);
            end
            total++;
            if (mem_oe && mem_we) begin
                bad++;
                $display("FAIL strobe_excl mem_oe=%b mem_we=%b expected not both", mem_oe, mem_we);
            end
            if (cpu_ack || vid_ack) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected cpu_ack=%b vid_ack=%b expected no ack", cpu_ack, vid_ack);
                end else begin
                    e   = exp_q.pop_front();
                    got = cpu_ack ? cpu_rdata : vid_rdata;
                    if (e.is_cpu !== cpu_ack || (!e.is_wr && got !== e.data)) begin
                        bad++;
                        $display("FAIL sb_ack owner=%b data=%h expected owner=%b data=%h",
                                 cpu_ack, got, e.is_cpu, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_50);
        #2;
    endtask

    task automatic wait_ph(input int n);
        int k = 0;
        do begin
            tick();
            k++;
        end while (ph != n && k < 100);
        total++;
        if (ph != n) begin
            bad++;
            $display("FAIL wait_ph got=%0d expected=%0d", ph, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;
        repeat (3) tick();
        @(negedge clock_50);
        total++;
        if ({cpu_ack, vid_ack, mem_oe, mem_we, overrun} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b expected=00000", {cpu_ack, vid_ack, mem_oe, mem_we, overrun});
        end
        total++;
        if ({mem_addr, mem_wdata, cpu_rdata, vid_rdata} !== 40'h0) begin
            bad++;
            $display("FAIL reset_dat got=%h expected=0", {mem_addr, mem_wdata, cpu_rdata, vid_rdata});
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        int acks = 0;
        wait_ph(0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        exp_q.push_back('{1'b1, 1'b0, 8'hA5});
        for (int c = 0; c < 10; c++) begin
            @(negedge clock_50);
            total++;
            if (mem_oe !== (ph >= 4 && ph <= 7)) begin
                bad++;
                $display("FAIL rd_oe ph=%0d got=%b expected=%b", ph, mem_oe, (ph >= 4 && ph <= 7));
            end
            total++;
            if (cpu_ack !== (ph == 8)) begin
                bad++;
                $display("FAIL rd_ack ph=%0d got=%b expected=%b", ph, cpu_ack, (ph == 8));
            end
            if (ph == 3) begin
                total++;
                if (mem_addr !== 16'h1234) begin
                    bad++;
                    $display("FAIL rd_addr got=%h expected=1234", mem_addr);
                end
            end
            if (cpu_ack) begin
                acks++;
                total++;
                if (cpu_rdata !== 8'hA5) begin
                    bad++;
                    $display("FAIL rd_data got=%h expected=a5", cpu_rdata);
                end
                cpu_req = 1'b0;
            end
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL rd_ack_count got=%0d expected=1", acks);
        end
    endtask

    task automatic test_cpu_write();
        int acks = 0;
        wait_ph(0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'h3C;
        exp_q.push_back('{1'b1, 1'b1, 8'h00});
        for (int c = 0; c < 10; c++) begin
            @(negedge clock_50);
            total++;
            if (mem_we !== (ph >= 4 && ph <= 7) || mem_oe !== 1'b0) begin
                bad++;
                $display("FAIL wr_strobe ph=%0d we=%b oe=%b expected we=%b oe=0",
                         ph, mem_we, mem_oe, (ph >= 4 && ph <= 7));
            end
            if (ph >= 3 && ph <= 8) begin
                total++;
                if (mem_addr !== 16'h0400 || mem_wdata !== 8'h3C) begin
                    bad++;
                    $display("FAIL wr_bus ph=%0d got=%h/%h expected=0400/3c", ph, mem_addr, mem_wdata);
                end
            end
            if (cpu_ack) begin
                acks++;
                cpu_req = 1'b0;
                cpu_we = 1'b0;
            end
        end
        total++;
        if (acks != 1 || ram[16'h0400] !== 8'h3C) begin
            bad++;
            $display("FAIL wr_result acks=%0d ram=%h expected acks=1 ram=3c", acks, ram[16'h0400]);
        end
    endtask

    task automatic test_video();
        int acks = 0;
        wait_ph(14);
        vid_req = 1'b1; vid_addr = 16'h2000;
        exp_q.push_back('{1'b0, 1'b0, 8'h11});
        for (int c = 0; c < 26; c++) begin
            @(negedge clock_50);
            total++;
            if (vid_ack !== (ph == 28 || ph == 38)) begin
                bad++;
                $display("FAIL vid_ack ph=%0d got=%b expected=%b", ph, vid_ack, (ph == 28 || ph == 38));
            end
            if (ph < 22) begin
                total++;
                if (mem_oe !== 1'b0) begin
                    bad++;
                    $display("FAIL vid_cpu_half ph=%0d mem_oe=%b expected=0", ph, mem_oe);
                end
            end
            if (vid_ack) begin
                acks++;
                if (acks == 1) begin
                    vid_addr = 16'h2001;
                    exp_q.push_back('{1'b0, 1'b0, 8'h22});
                end else begin
                    vid_req = 1'b0;
                end
            end
        end
        total++;
        if (acks != 2 || vid_rdata !== 8'h22) begin
            bad++;
            $display("FAIL vid_count acks=%0d rdata=%h expected acks=2 rdata=22", acks, vid_rdata);
        end
    endtask

    task automatic test_steal();
        int strobes = 0;
        int ack_ph = -1;
        wait_ph(0);
        cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h2002;
        exp_q.push_back('{1'b0, 1'b0, 8'h33});
        for (int c = 0; c < 40; c++) begin
            @(negedge clock_50);
            if (ph < 20 && (mem_oe || mem_we)) strobes++;
            if (vid_ack) begin
                ack_ph = ph;
                vid_req = 1'b0;
            end
        end
        total++;
        if (strobes != STEAL_STROBES) begin
            bad++;
            $display("FAIL steal_strobes got=%0d expected=%0d", strobes, STEAL_STROBES);
        end
        total++;
        if (ack_ph != STEAL_ACK_PH || vid_rdata !== 8'h33) begin
            bad++;
            $display("FAIL steal_ack ph=%0d rdata=%h expected ph=%0d rdata=33", ack_ph, vid_rdata, STEAL_ACK_PH);
        end
    endtask

    task automatic test_reset_mid_slot();
        wait_ph(0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        wait_ph(5);
        reset = 1'b1;
        @(negedge clock_50);
        @(negedge clock_50);
        total++;
        if (mem_oe !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_drop oe=%b ack=%b expected 0/0", mem_oe, cpu_ack);
        end
        wait_ph(8);
        reset = 1'b0;
        exp_q.push_back('{1'b1, 1'b0, 8'hA5});
        for (int c = 0; c < 15; c++) begin
            @(negedge clock_50);
            total++;
            if (cpu_ack !== (ph == 18)) begin
                bad++;
                $display("FAIL mid_reset_ack ph=%0d got=%b expected=%b", ph, cpu_ack, (ph == 18));
            end
            if (cpu_ack) cpu_req = 1'b0;
        end
        total++;
        if (cpu_rdata !== 8'hA5) begin
            bad++;
            $display("FAIL mid_reset_data got=%h expected=a5", cpu_rdata);
        end
    endtask

    task automatic test_overrun();
        int acks = 0;
        bit seen = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_initial got=%b expected=0", overrun);
        end
        tick();
        fast = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        exp_q.push_back('{1'b1, 1'b0, 8'hA5});
        for (int c = 0; c < 30; c++) begin
            @(negedge clock_50);
            if (seen) begin
                total++;
                if (overrun !== 1'b1) begin
                    bad++;
                    $display("FAIL ovr_sticky cycle=%0d got=%b expected=1", c, overrun);
                end
            end
            if (overrun === 1'b1) seen = 1'b1;
            if (cpu_ack) begin
                acks++;
                cpu_req = 1'b0;
            end
        end
        total++;
        if (acks != 1 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_result acks=%0d overrun=%b expected acks=1 overrun=1", acks, overrun);
        end
        tick();
        fast = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_video();
        test_steal();
        test_reset_mid_slot();
        test_overrun();
        repeat (4) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
